// File: rtl/id_ctrl_gen_pkg.sv
// Shared types and encodings for the miniRV decode stage: ALU ops, opcodes,
// funct3 values and the decoded control bundle carried through the skid buffer.
package id_ctrl_gen_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_BEQ = 4'd8,
    ALU_BNE = 4'd9,
    ALU_BLT = 4'd10,
    ALU_BGE = 4'd11
  } alu_op_e;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_B   = 7'b1100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef struct packed {
    alu_op_e         op;
    logic            sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic            branch;
    logic            jal;
    logic            illegal;
  } dec_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    dec_t            dec;
  } bundle_t;

  typedef struct packed {
    logic    ok;
    alu_op_e op;
  } f3_op_t;

  // Arithmetic funct3 decode shared by R and I formats; alt_add selects SUB
  // for funct3=000 and only applies to the R format.
  function automatic f3_op_t f3_to_op(input logic [2:0] f3, input logic alt,
                                      input logic alt_add);
    f3_op_t r;
    r.ok = 1'b1;
    r.op = ALU_ADD;
    case (f3)
      F3_ADD:  r.op = (alt && alt_add) ? ALU_SUB : ALU_ADD;
      F3_SLL:  r.op = ALU_SLL;
      F3_XOR:  r.op = ALU_XOR;
      F3_SR:   r.op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   r.op = ALU_OR;
      F3_AND:  r.op = ALU_AND;
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_ctrl_gen_decode.sv
// Purely combinational RV32I subset decoder: instruction word to control
// bundle, including immediate generation for every supported format.
module id_ctrl_gen_decode
  import id_ctrl_gen_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        f7b;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  f3_op_t      arith;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7b = inst[30];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path through the case tree leaves a latch behind.
  always_comb begin
    dec     = '0;
    dec.op  = ALU_ADD;
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    dec.rd  = inst[11:7];
    arith   = f3_to_op(f3, f7b, opc == OPC_R);

    case (opc)
      OPC_R: begin
        dec.reg_we  = 1'b1;
        dec.op      = arith.op;
        dec.illegal = !arith.ok;
      end
      OPC_I: begin
        dec.reg_we  = 1'b1;
        dec.sel     = 1'b1;
        dec.imm     = imm_i;
        dec.op      = arith.op;
        dec.illegal = !arith.ok;
      end
      OPC_LD: begin
        dec.sel     = 1'b1;
        dec.imm     = imm_i;
        dec.reg_we  = 1'b1;
        dec.mem_re  = 1'b1;
        dec.illegal = (f3 != F3_W);
      end
      OPC_ST: begin
        dec.sel     = 1'b1;
        dec.imm     = imm_s;
        dec.mem_we  = 1'b1;
        dec.illegal = (f3 != F3_W);
      end
      OPC_B: begin
        dec.imm    = imm_b;
        dec.branch = 1'b1;
        case (f3)
          F3_BEQ:  dec.op = ALU_BEQ;
          F3_BNE:  dec.op = ALU_BNE;
          F3_BLT:  dec.op = ALU_BLT;
          F3_BGE:  dec.op = ALU_BGE;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.sel    = 1'b1;
        dec.imm    = imm_u;
        dec.rs1    = 5'd0;
        dec.reg_we = 1'b1;
      end
      OPC_JAL: begin
        dec.imm    = imm_j;
        dec.jal    = 1'b1;
        dec.reg_we = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase

    // Illegal encodings still flow downstream but must not cause side effects.
    if (dec.illegal) begin
      dec.op     = ALU_ADD;
      dec.sel    = 1'b0;
      dec.imm    = '0;
      dec.reg_we = 1'b0;
      dec.mem_re = 1'b0;
      dec.mem_we = 1'b0;
      dec.branch = 1'b0;
      dec.jal    = 1'b0;
    end
  end

endmodule

// File: rtl/id_ctrl_gen.sv
// miniRV decode stage: combinational decode registered through a 2-entry
// skid buffer (main reg M drives outputs, skid reg S absorbs one stall).
module id_ctrl_gen
  import id_ctrl_gen_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [31:0]     in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [OP_W-1:0] out_op,
  output logic            out_sel,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_reg_we,
  output logic            out_mem_re,
  output logic            out_mem_we,
  output logic            out_branch,
  output logic            out_jal,
  output logic            out_illegal
);

  // Occupancy: EMPTY (nothing), ONE (M valid), FULL (M and S valid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e  state_q, state_d;
  bundle_t m_q, s_q, in_b;
  dec_t    in_dec;
  logic    load_m, m_from_s, load_s;

  id_ctrl_gen_decode u_decode (
    .inst (in_inst),
    .dec  (in_dec)
  );

  assign in_b = '{pc: in_pc, dec: in_dec};

  always_comb begin
    state_d  = state_q;
    load_m   = 1'b0;
    m_from_s = 1'b0;
    load_s   = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            load_m  = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (out_ready) begin
            // Drain and refill in the same cycle keeps full throughput.
            if (in_valid) load_m = 1'b1;
            else          state_d = ST_EMPTY;
          end else if (in_valid) begin
            load_s  = 1'b1;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            load_m   = 1'b1;
            m_from_s = 1'b1;
            state_d  = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values, regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: the payload registers are reset too, because the outputs must read
  // all-zero after reset; otherwise they would be left unreset as plain data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m) m_q <= m_from_s ? s_q : in_b;
      if (load_s) s_q <= in_b;
    end
  end

  assign in_ready    = (state_q != ST_FULL);
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_pc      = m_q.pc;
  assign out_op      = m_q.dec.op;
  assign out_sel     = m_q.dec.sel;
  assign out_imm     = m_q.dec.imm;
  assign out_rs1     = m_q.dec.rs1;
  assign out_rs2     = m_q.dec.rs2;
  assign out_rd      = m_q.dec.rd;
  assign out_reg_we  = m_q.dec.reg_we;
  assign out_mem_re  = m_q.dec.mem_re;
  assign out_mem_we  = m_q.dec.mem_we;
  assign out_branch  = m_q.dec.branch;
  assign out_jal     = m_q.dec.jal;
  assign out_illegal = m_q.dec.illegal;

endmodule

// File: tb/tb_id_ctrl_gen.sv
// Scoreboard bench for id_ctrl_gen: the driver queues hand-computed bundles on
// each accepted instruction, the monitor pops and compares on each output transfer.
module tb_id_ctrl_gen;
  import id_ctrl_gen_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op;
    logic        sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        re;
    logic        mw;
    logic        br;
    logic        jal;
    logic        ill;
  } exp_t;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [3:0]  out_op;
  logic        out_sel, out_reg_we, out_mem_re, out_mem_we, out_branch, out_jal, out_illegal;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  id_ctrl_gen dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_sel(out_sel), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_reg_we(out_reg_we), .out_mem_re(out_mem_re),
    .out_mem_we(out_mem_we), .out_branch(out_branch), .out_jal(out_jal),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [31:0] inst_tab [12];
  exp_t        exp_tab  [12];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [89:0] act, input logic [89:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic sel, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [5:0] flags);
    exp_t e;
    e.pc = '0; e.op = op; e.sel = sel; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    {e.we, e.re, e.mw, e.br, e.jal, e.ill} = flags;
    return e;
  endfunction

  function automatic exp_t dut_bundle();
    return {out_pc, out_op, out_sel, out_imm, out_rs1, out_rs2, out_rd,
            out_reg_we, out_mem_re, out_mem_we, out_branch, out_jal, out_illegal};
  endfunction

  // Drive at posedge+2; in_ready is registered so its value here decides the next edge.
  task automatic send(input int idx, input logic [31:0] pc);
    exp_t e;
    int   budget = 0;
    in_valid = 1'b1;
    in_inst  = inst_tab[idx];
    in_pc    = pc;
    while (!in_ready && budget < 50) begin
      @(posedge clk); #2;
      budget++;
    end
    if (!in_ready) begin
      check("in_ready timeout", 90'(in_ready), 90'(1));
    end else begin
      e = exp_tab[idx];
      e.pc = pc;
      exp_q.push_back(e);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
  endtask

  // Monitor: compares on each transfer and checks payload stability under stall.
  exp_t held;
  logic held_v = 1'b0;
  always @(negedge clk) begin
    if (out_valid) begin
      if (held_v) check("stall stable", dut_bundle(), held);
      if (out_ready) begin
        if (exp_q.size() == 0) check("unexpected output", 90'(1), 90'(0));
        else check($sformatf("bundle pc=%h", exp_q[0].pc), dut_bundle(), exp_q.pop_front());
        held_v = 1'b0;
      end else begin
        held   = dut_bundle();
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    int start, budget;
    //                           op       sel imm           rs1 rs2 rd  we re mw br jal ill
    inst_tab[0]  = 32'h002081B3; exp_tab[0]  = mk(ALU_ADD, 0, 32'h0,        1,  2,  3,  6'b100000);
    inst_tab[1]  = 32'h40315113; exp_tab[1]  = mk(ALU_SRA, 1, 32'h00000403, 2,  3,  2,  6'b100000);
    inst_tab[2]  = 32'hFFF00093; exp_tab[2]  = mk(ALU_ADD, 1, 32'hFFFFFFFF, 0,  31, 1,  6'b100000);
    inst_tab[3]  = 32'hFE208EE3; exp_tab[3]  = mk(ALU_BEQ, 0, 32'hFFFFFFFC, 1,  2,  29, 6'b000100);
    inst_tab[4]  = 32'h00000000; exp_tab[4]  = mk(ALU_ADD, 0, 32'h0,        0,  0,  0,  6'b000001);
    inst_tab[5]  = 32'h00832283; exp_tab[5]  = mk(ALU_ADD, 1, 32'h8,        6,  8,  5,  6'b110000);
    inst_tab[6]  = 32'hFE712C23; exp_tab[6]  = mk(ALU_ADD, 1, 32'hFFFFFFF8, 2,  7,  24, 6'b001000);
    inst_tab[7]  = 32'h12345237; exp_tab[7]  = mk(ALU_ADD, 1, 32'h12345000, 0,  3,  4,  6'b100000);
    inst_tab[8]  = 32'h010000EF; exp_tab[8]  = mk(ALU_ADD, 0, 32'h10,       0,  16, 1,  6'b100010);
    inst_tab[9]  = 32'h407302B3; exp_tab[9]  = mk(ALU_SUB, 0, 32'h0,        6,  7,  5,  6'b100000);
    inst_tab[10] = 32'h0041D463; exp_tab[10] = mk(ALU_BGE, 0, 32'h8,        3,  4,  8,  6'b000100);
    inst_tab[11] = 32'h003140B3; exp_tab[11] = mk(ALU_XOR, 0, 32'h0,        2,  3,  1,  6'b100000);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_pc = '0;
    #12;
    check("reset out_valid", 90'(out_valid), 90'(0));
    check("reset in_ready", 90'(in_ready), 90'(1));
    check("reset payload", dut_bundle(), 90'(0));
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Full-throughput stream of every vector, first one checked for 1-cycle latency.
    start = cyc;
    send(0, 32'h1000);
    check("latency out_valid", 90'(out_valid), 90'(1));
    for (int i = 1; i < 12; i++) send(i, 32'h1000 + 32'(4 * i));
    check("throughput cycles", 90'(cyc - start), 90'(12));
    repeat (3) begin @(posedge clk); #2; end

    // Stall: out_ready low for 3 edges while 4 instructions stream in.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 5; i < 9; i++) send(i, 32'h2000 + 32'(4 * i));
      end
      begin
        repeat (2) begin @(posedge clk); #2; end
        check("stall in_ready low", 90'(in_ready), 90'(0));
        @(posedge clk); #2;
        check("stall in_ready still low", 90'(in_ready), 90'(0));
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check($sformatf("no gap %0d", k), 90'(out_valid), 90'(1));
        end
      end
    join
    repeat (3) begin @(posedge clk); #2; end

    // Flush with M and S full and an instruction on the input.
    out_ready = 1'b0;
    send(9, 32'h3000);
    send(10, 32'h3004);
    check("full before flush", 90'(in_ready), 90'(0));
    in_valid = 1'b1; in_inst = inst_tab[11]; in_pc = 32'h3008; flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0; in_valid = 1'b0;
    check("flush out_valid", 90'(out_valid), 90'(0));
    check("flush in_ready", 90'(in_ready), 90'(1));
    exp_q.delete();
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #2; end
    check("flush nothing emitted", 90'(out_valid), 90'(0));

    // Asynchronous reset with S full.
    out_ready = 1'b0;
    send(0, 32'h4000);
    send(1, 32'h4004);
    #1 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 90'(out_valid), 90'(0));
    check("async rst in_ready", 90'(in_ready), 90'(1));
    check("async rst payload", dut_bundle(), 90'(0));
    exp_q.delete();
    #20 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #2;
    send(3, 32'h5000);

    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk); #2;
      budget++;
    end
    check("scoreboard drained", 90'(exp_q.size()), 90'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
